// File: rtl/audio_sample_fetcher.sv
// Sample fetcher for the audio channel bank: on each lrclk rising edge it sweeps the
// active channels and reads one 16-bit sample per channel through a single memory port.
module audio_sample_fetcher #(
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lrclk,
    input  logic [CHANNELS*ADDR_W-1:0]   i_channelAddress,
    input  logic [CHANNELS-1:0]          i_channelActive,
    output logic                         o_memReq,
    output logic [ADDR_W-1:0]            o_memAddr,
    input  logic                         i_memAck,
    input  logic [15:0]                  i_memData,
    output logic [CHANNELS*16-1:0]       o_sample,
    output logic [CHANNELS-1:0]          o_ready,
    output logic [15:0]                  o_underrunCount
);

    // idx must be able to reach CHANNELS (one past the last slot)
    localparam int IDX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SCAN,
        S_FETCH,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic               r_lrclkPrev;
    logic               w_tick;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idxNext;
    logic               r_discard;
    logic               w_discardNext;
    logic               w_reqNext;
    logic               w_addrLoad;
    logic               w_write;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [ADDR_W-1:0]  w_selAddr;

    function automatic logic [4:0] popcount(input logic [CHANNELS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            n = n + {4'b0, v[k]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_tick = lrclk & ~r_lrclkPrev;

    // Descending loop so the lowest qualifying slot wins
    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_selAddr = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (i_channelActive[k] && (IDX_W'(k) >= r_idx)) begin
                w_found   = 1'b1;
                w_sel     = IDX_W'(k);
                w_selAddr = i_channelAddress[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_idxNext     = r_idx;
        w_discardNext = r_discard;
        w_reqNext     = o_memReq;
        w_addrLoad    = 1'b0;
        w_write       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_stateNext = S_SETTLE;
                    w_idxNext   = '0;
                end
            end
            S_SETTLE: begin
                w_idxNext   = '0;
                w_stateNext = w_tick ? S_SETTLE : S_SCAN;
            end
            S_SCAN: begin
                if (w_tick) begin
                    w_stateNext = S_SETTLE;
                    w_idxNext   = '0;
                    w_reqNext   = 1'b0;
                end else if (w_found) begin
                    w_stateNext = S_FETCH;
                    w_idxNext   = w_sel;
                    w_reqNext   = 1'b1;
                    w_addrLoad  = 1'b1;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            S_FETCH: begin
                // A tick cannot withdraw the request; it only marks the reply as stale
                if (i_memAck) begin
                    w_reqNext = 1'b0;
                    if (w_tick || r_discard) begin
                        w_stateNext   = S_SETTLE;
                        w_idxNext     = '0;
                        w_discardNext = 1'b0;
                    end else begin
                        w_write     = 1'b1;
                        w_idxNext   = r_idx + IDX_W'(1);
                        w_stateNext = S_GAP;
                    end
                end else if (w_tick) begin
                    w_discardNext = 1'b1;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_stateNext = S_SETTLE;
                    w_idxNext   = '0;
                end else begin
                    w_stateNext = S_SCAN;
                end
            end
            default: begin
                w_stateNext   = S_IDLE;
                w_idxNext     = '0;
                w_discardNext = 1'b0;
                w_reqNext     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_lrclkPrev     <= 1'b0;
            r_idx           <= '0;
            r_discard       <= 1'b0;
            o_memReq        <= 1'b0;
            o_memAddr       <= '0;
            o_sample        <= '0;
            o_ready         <= '0;
            o_underrunCount <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_lrclkPrev <= lrclk;
            r_idx       <= w_idxNext;
            r_discard   <= w_discardNext;
            o_memReq    <= w_reqNext;
            if (w_addrLoad) begin
                o_memAddr <= w_selAddr;
            end
            // Channels consume o_ready in the tick cycle, so count misses before clearing
            if (w_tick) begin
                o_ready         <= '0;
                o_underrunCount <= sat_add(o_underrunCount,
                                           popcount(i_channelActive & ~o_ready));
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_write && (r_idx == IDX_W'(k))) begin
                    o_ready[k]           <= 1'b1;
                    o_sample[k*16 +: 16] <= i_memData;
                end
            end
        end
    end

endmodule
